// File: rtl/stress_pkg.sv
// rtl/stress_pkg.sv - shared types and constants for the stress classifier core
//
// Purpose: FSM state enum, INT8 requant saturation limits and an index-width
//          helper used to size address/class/counter fields.
// Ports:   none (package).
package stress_pkg;

  typedef enum logic [1:0] {
    S_CONV = 2'd0,
    S_FC   = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam int SAT_MIN = 0;
  localparam int SAT_MAX = 127;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stress_mac_unit.sv
// rtl/stress_mac_unit.sv - signed multiply-accumulate with clear and enable
//
// Purpose: acc <= acc + sext(a*b) when en; acc <= 0 when clr (clr wins).
//          sum exposes acc + product combinationally so the caller can use
//          the completed total on the same edge that clears the accumulator.
// Ports:   clk, rst_n (async active-low), clr, en,
//          a/b (signed PIXEL_WIDTH), acc/sum (signed ACC_WIDTH).
module stress_mac_unit #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [PIXEL_WIDTH-1:0] a,
  input  logic signed [PIXEL_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]   acc,
  output logic signed [ACC_WIDTH-1:0]   sum
);

  logic signed [2*PIXEL_WIDTH-1:0] prod;

  assign prod = a * b;
  // Signed size cast sign-extends the full-precision product; the add wraps.
  assign sum  = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/stress_classifier_core.sv
// rtl/stress_classifier_core.sv - streaming conv/ReLU/requant/FC/argmax classifier
//
// Purpose: accepts KERNEL_TAPS pixel/weight pairs per feature, NUM_FEATURES
//          features per sample, then runs a class-major FC over runtime-loaded
//          weights and presents the argmax class until the consumer takes it.
// Ports:   clk, rst_n (async active-low)
//          in_valid/in_ready, pixel_in, weight_in       - conv tap stream
//          wt_wr_en, wt_wr_addr, wt_wr_data             - FC weight writes
//          pred_valid/pred_ready, pred_class            - result handshake
//          pred_score (only with STRESS_CLS_SCORE_EN)   - winning logit
// Config:  `STRESS_CLS_SCORE_EN adds the pred_score port.
module stress_classifier_core
  import stress_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int KERNEL_TAPS  = 9,
  parameter int NUM_FEATURES = 4,
  parameter int NUM_CLASSES  = 2,
  parameter int QSHIFT       = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [PIXEL_WIDTH-1:0]                 pixel_in,
  input  logic signed [PIXEL_WIDTH-1:0]                 weight_in,
  input  logic                                          wt_wr_en,
  input  logic [idx_w(NUM_CLASSES*NUM_FEATURES)-1:0]    wt_wr_addr,
  input  logic signed [PIXEL_WIDTH-1:0]                 wt_wr_data,
  output logic                                          pred_valid,
  input  logic                                          pred_ready,
  output logic [idx_w(NUM_CLASSES)-1:0]                 pred_class
`ifdef STRESS_CLS_SCORE_EN
  ,
  output logic signed [ACC_WIDTH-1:0]                   pred_score
`endif
);

  localparam int NW = NUM_CLASSES * NUM_FEATURES;
  localparam int AW = idx_w(NW);
  localparam int CW = idx_w(NUM_CLASSES);
  localparam int TW = idx_w(KERNEL_TAPS);
  localparam int FW = idx_w(NUM_FEATURES);

  state_e state, next_state;

  logic [TW-1:0] tap_cnt;
  logic [FW-1:0] feat_cnt;
  logic [FW-1:0] fc_f;
  logic [CW-1:0] fc_c;
  logic [AW-1:0] fc_idx;

  logic signed [PIXEL_WIDTH-1:0] feat [NUM_FEATURES];
  logic signed [PIXEL_WIDTH-1:0] fcw  [NW];

  logic signed [ACC_WIDTH-1:0] best_logit;
  logic [CW-1:0]               best_class;

  logic                          mac_en, mac_clr;
  logic signed [PIXEL_WIDTH-1:0] mac_a, mac_b;
  logic signed [ACC_WIDTH-1:0]   mac_acc, mac_sum;

  logic last_tap, last_feat, fc_last_f, fc_last_c, wt_wr_ok;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic signed [PIXEL_WIDTH-1:0] q;

  assign last_tap  = (tap_cnt  == TW'(KERNEL_TAPS - 1));
  assign last_feat = (feat_cnt == FW'(NUM_FEATURES - 1));
  assign fc_last_f = (fc_f     == FW'(NUM_FEATURES - 1));
  assign fc_last_c = (fc_c     == CW'(NUM_CLASSES - 1));

  // FC weights are frozen while the FC MAC is walking them.
  assign wt_wr_ok = wt_wr_en && (state != S_FC) && (int'(wt_wr_addr) < NW);

  // One MAC serves both phases; operands are muxed by state.
  stress_mac_unit #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (mac_a),
    .b    (mac_b),
    .acc  (mac_acc),
    .sum  (mac_sum)
  );

  // ReLU then arithmetic shift then clamp to the positive INT8 range.
  always_comb begin
    shifted = mac_sum >>> QSHIFT;
    if (mac_sum < 0) begin
      q = PIXEL_WIDTH'(SAT_MIN);
    end else if (shifted > $signed(ACC_WIDTH'(SAT_MAX))) begin
      q = PIXEL_WIDTH'(SAT_MAX);
    end else begin
      q = shifted[PIXEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CONV;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    pred_valid = 1'b0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    mac_a      = pixel_in;
    mac_b      = weight_in;
    case (state)
      S_CONV: begin
        in_ready = 1'b1;
        mac_en   = in_valid;
        // The final tap's total is consumed via mac_sum, so clear on that edge.
        mac_clr  = in_valid && last_tap;
        if (in_valid && last_tap && last_feat) begin
          next_state = S_FC;
        end
      end
      S_FC: begin
        mac_a   = feat[fc_f];
        mac_b   = fcw[fc_idx];
        mac_en  = 1'b1;
        mac_clr = fc_last_f;
        if (fc_last_f && fc_last_c) begin
          next_state = S_OUT;
        end
      end
      S_OUT: begin
        pred_valid = 1'b1;
        if (pred_ready) begin
          next_state = S_CONV;
        end
      end
      default: begin
        next_state = S_CONV;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt    <= '0;
      feat_cnt   <= '0;
      fc_f       <= '0;
      fc_c       <= '0;
      fc_idx     <= '0;
      best_logit <= '0;
      best_class <= '0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
        feat[i] <= '0;
      end
      for (int i = 0; i < NW; i++) begin
        fcw[i] <= '0;
      end
    end else begin
      if (wt_wr_ok) begin
        fcw[wt_wr_addr] <= wt_wr_data;
      end
      case (state)
        S_CONV: begin
          if (in_valid) begin
            if (last_tap) begin
              tap_cnt        <= '0;
              feat[feat_cnt] <= q;
              feat_cnt       <= last_feat ? '0 : feat_cnt + 1'b1;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
            end
          end
        end
        S_FC: begin
          if (fc_last_f) begin
            fc_f <= '0;
            // Strictly-greater keeps the lowest index on ties.
            if ((fc_c == '0) || (mac_sum > best_logit)) begin
              best_logit <= mac_sum;
              best_class <= fc_c;
            end
            if (fc_last_c) begin
              fc_c   <= '0;
              fc_idx <= '0;
            end else begin
              fc_c   <= fc_c + 1'b1;
              fc_idx <= fc_idx + 1'b1;
            end
          end else begin
            fc_f   <= fc_f + 1'b1;
            fc_idx <= fc_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pred_class = best_class;
`ifdef STRESS_CLS_SCORE_EN
  assign pred_score = best_logit;
`endif

endmodule
